// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Optional overflow output: DIGIT_SERIAL_ADDER_OVERFLOW_EN.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_nchunks(input int numbits, input int chunkbits);
        return numbits / chunkbits;
    endfunction

    function automatic int calc_cntw(input int nchunks);
        return (nchunks > 1) ? $clog2(nchunks) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_chunk.sv
// Combinational W-bit ripple adder slice; also exposes the carry into
// its MSB so the top can derive signed overflow on the final chunk.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor, CHUNKBITS per clock, LSB chunk first.
// Define DIGIT_SERIAL_ADDER_OVERFLOW_EN to add the overflow output.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int NUMBITS   = 16,
    parameter int CHUNKBITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               carryin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic               overflow
`endif
);

    localparam int NCH = calc_nchunks(NUMBITS, CHUNKBITS);
    localparam int CW  = calc_cntw(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_t             state_q, state_d;
    logic [NUMBITS-1:0] opa_q, opa_d;
    logic [NUMBITS-1:0] opb_q, opb_d;
    logic [NUMBITS-1:0] acc_q, acc_d;
    logic [NUMBITS-1:0] res_q, res_d;
    logic [NUMBITS-1:0] acc_next;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               valid_q, valid_d;

    logic [CHUNKBITS-1:0] csum;
    logic                 ccout;

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic cmsb;
`else
    logic cmsb_unused;
`endif

    chunk_adder #(
        .W(CHUNKBITS)
    ) u_chunk (
        .a        (opa_q[CHUNKBITS-1:0]),
        .b        (opb_q[CHUNKBITS-1:0]),
        .cin      (carry_q),
        .sum      (csum),
        .cout     (ccout),
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        .c_msb_in (cmsb)
`else
        .c_msb_in (cmsb_unused)
`endif
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = valid_q;
    assign result    = res_q;
    assign carryout  = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

    // New chunk enters at the top so the last one lands in the MSBs.
    assign acc_next = (acc_q >> CHUNKBITS)
                    | (NUMBITS'(csum) << (NUMBITS - CHUNKBITS));

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        valid_d = valid_q;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtract as A + ~B + ~borrow.
                    opa_d   = A;
                    opb_d   = sub ? ~B : B;
                    carry_d = carryin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> CHUNKBITS;
                opb_d   = opb_q >> CHUNKBITS;
                acc_d   = acc_next;
                carry_d = ccout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = acc_next;
                    cout_d  = ccout;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
                    ovf_d   = cmsb ^ ccout;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed scoreboard bench for digit_serial_adder (4-bit and 16-bit chunks).
// Overflow checks are active when DIGIT_SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_digit_serial_adder;

    typedef struct packed {
        logic [15:0] r;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sel;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin_in;
    logic        sub_in;
    logic        out_ready;

    logic        rdy0, ov0, co0;
    logic        rdy1, ov1, co1;
    logic [15:0] res0, res1;
    logic        rdy_s, ov_s, co_s;
    logic [15:0] res_s;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    logic        ovf0, ovf1, ovf_s;
`endif

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    digit_serial_adder #(.NUMBITS(16), .CHUNKBITS(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy0),
        .A(a_in), .B(b_in), .carryin(cin_in), .sub(sub_in),
        .out_valid(ov0), .out_ready(out_ready & ~sel),
        .result(res0), .carryout(co0)
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf0)
`endif
    );

    digit_serial_adder #(.NUMBITS(16), .CHUNKBITS(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy1),
        .A(a_in), .B(b_in), .carryin(cin_in), .sub(sub_in),
        .out_valid(ov1), .out_ready(out_ready & sel),
        .result(res1), .carryout(co1)
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf1)
`endif
    );

    assign rdy_s = sel ? rdy1 : rdy0;
    assign ov_s  = sel ? ov1  : ov0;
    assign co_s  = sel ? co1  : co0;
    assign res_s = sel ? res1 : res0;
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
    assign ovf_s = sel ? ovf1 : ovf0;
`endif

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic s);
        exp_t e;
        int u, v;
        if (!s) begin
            u = int'(a) + int'(b) + int'(ci);
            v = int'($signed(a)) + int'($signed(b)) + int'(ci);
            e.co = (u > 65535);
        end else begin
            u = int'(a) - int'(b) - int'(ci);
            v = int'($signed(a)) - int'($signed(b)) - int'(ci);
            e.co = (u >= 0);
        end
        e.r  = u[15:0];
        e.ov = (v > 32767) || (v < -32768);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic s);
        int n = 0;
        while (!rdy_s && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", 32'(rdy_s), 32'd1);
        a_in = a; b_in = b; cin_in = ci; sub_in = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(a, b, ci, s));
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int n = 0;
        while (!ov_s && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
    endtask

    task automatic check_res(input string tag, output exp_t e);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_result"}, 32'(res_s), 32'(e.r));
        chk({tag, "_carryout"}, 32'(co_s), 32'(e.co));
`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
        chk({tag, "_overflow"}, 32'(ovf_s), 32'(e.ov));
`endif
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_cleared"}, 32'(ov_s), 32'd0);
        chk({tag, "_ready_again"}, 32'(rdy_s), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input int lat);
        exp_t e;
        start_op(a, b, ci, s);
        wait_valid(tag, lat);
        check_res(tag, e);
        release_res(tag);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        @(posedge clk); #1;
        chk("ready_low_in_reset", 32'(rdy_s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_valid", 32'(ov_s), 32'd0);
        chk("reset_result", 32'(res_s), 32'd0);
        chk("reset_carryout", 32'(co_s), 32'd0);
        chk("reset_ready", 32'(rdy_s), 32'd1);

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 4);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4);
        run_op("add_wrap_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 4);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b0 | 1'b1, 4);
        run_op("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 4);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 4);
        run_op("add_mixed", 16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 4);

        // Backpressure: result must hold and new operands must be ignored.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_valid("bp", 4);
        check_res("bp", e);
        for (int i = 0; i < 5; i++) begin
            a_in = 16'($urandom); b_in = 16'($urandom);
            cin_in = 1'($urandom); sub_in = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(ov_s), 32'd1);
            chk("bp_hold_ready", 32'(rdy_s), 32'd0);
            chk("bp_hold_result", 32'(res_s), 32'(e.r));
            chk("bp_hold_carry", 32'(co_s), 32'(e.co));
        end
        in_valid = 1'b0;
        release_res("bp");
        run_op("after_bp", 16'h0001, 16'h0002, 1'b0, 1'b0, 4);

        // Reset mid-RUN discards the operation.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_valid", 32'(ov_s), 32'd0);
        chk("midrun_rst_result", 32'(res_s), 32'd0);
        chk("midrun_rst_carry", 32'(co_s), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrun_rst_ready", 32'(rdy_s), 32'd1);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4);

        // Single-chunk instance: one cycle latency.
        sel = 1'b1;
        #1;
        run_op("nch1_add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
        run_op("nch1_sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 1);
        run_op("nch1_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
